tx_link_scheduler: RTL

//   Sequences the BPSK transmitter byte path: buffers host (UART) payloads, arbitrates them against an

---
 rtl/tx_link_scheduler_pkg.sv | 25 ++
 rtl/tx_link_scheduler_frame_buffer.sv | 63 ++++++
 rtl/tx_link_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_link_scheduler_pkg.sv
// Shared types and constants for the BPSK transmitter byte-path scheduler.
// Frame layout: preamble, sync, length, payload, checksum.
package tx_link_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_SLEEP,
        ST_WAKE,
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } tx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] BEACON_TAG    = 8'hBE;
    localparam logic [7:0] BEACON_LEN    = 8'd2;

    // Beacon payload is the tag byte followed by the sequence number.
    function automatic logic [7:0] beacon_byte(input logic [7:0] idx, input logic [7:0] seq);
        return (idx == 8'd0) ? BEACON_TAG : seq;
    endfunction

endpackage

// File: rtl/tx_link_scheduler_frame_buffer.sv
// Host payload buffer: collects one host frame, closes on host_last or when full,
// and is replayed byte by byte while the frame is transmitted.
module tx_link_scheduler_frame_buffer #(
    parameter int MAX_PAYLOAD = 16
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    input  logic       host_last,
    output logic       host_ready,
    input  logic       release_buf,
    input  logic       rd_next,
    output logic [7:0] rd_data,
    output logic [7:0] count,
    output logic       closed,
    output logic       truncated
);

    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    logic [7:0]    mem [MAX_PAYLOAD];
    logic [7:0]    wr_count;
    logic [AW-1:0] rd_ptr;
    logic          accept;
    logic          at_limit;

    assign host_ready = !closed && (wr_count < 8'(MAX_PAYLOAD));
    assign accept     = host_valid && host_ready;
    assign at_limit   = (wr_count == 8'(MAX_PAYLOAD - 1));
    assign rd_data    = mem[rd_ptr];
    assign count      = wr_count;

    // NOTE: storage has no reset; wr_count alone decides which entries are meaningful.
    always_ff @(posedge sysclk) begin
        if (accept) mem[wr_count[AW-1:0]] <= host_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count  <= '0;
            rd_ptr    <= '0;
            closed    <= 1'b0;
            truncated <= 1'b0;
        end else begin
            truncated <= 1'b0;
            if (release_buf) begin
                wr_count <= '0;
                rd_ptr   <= '0;
                closed   <= 1'b0;
            end else begin
                if (accept) begin
                    wr_count <= wr_count + 8'd1;
                    if (host_last || at_limit) closed <= 1'b1;
                    if (!host_last && at_limit) truncated <= 1'b1;
                end
                if (rd_next) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_link_scheduler.sv
// Transmit byte-path scheduler: arbitrates host frames against a periodic beacon,
// frames the winner for the modulator and owns modulator sleep/wake.
module tx_link_scheduler
    import tx_link_scheduler_pkg::*;
#(
    parameter int         PREAMBLE_BYTES = 4,
    parameter logic [7:0] SYNC_WORD      = 8'hD3,
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         BEACON_PERIOD  = 1_000_000,
    parameter int         WAKE_CYCLES    = 64,
    parameter int         IDLE_CYCLES    = 4096
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    input  logic       host_last,
    output logic       host_ready,
    input  logic       beacon_en,
    output logic       mod_valid,
    output logic [7:0] mod_data,
    input  logic       mod_ready,
    output logic       mod_sleep,
    output logic       active_src,
    output logic       frame_done,
    output logic       truncated
);

    localparam int WAIT_MAX = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int BCN_W    = $clog2(BEACON_PERIOD);

    tx_state_t   state;
    logic [7:0]  byte_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]  frame_len;
    logic [7:0]  csum;
    logic [7:0]  seq;
    logic [BCN_W-1:0] beacon_timer;
    logic        beacon_pending;

    logic        xfer;
    logic        host_pending;
    logic        grant;
    logic        last_payload;
    logic        rd_next;
    logic        release_buf;
    logic [7:0]  next_idx;
    logic [7:0]  payload_next;
    logic [7:0]  buf_rd_data;
    logic [7:0]  buf_count;
    logic        buf_closed;

    tx_link_scheduler_frame_buffer #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_buf (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_last   (host_last),
        .host_ready  (host_ready),
        .release_buf (release_buf),
        .rd_next     (rd_next),
        .rd_data     (buf_rd_data),
        .count       (buf_count),
        .closed      (buf_closed),
        .truncated   (truncated)
    );

    // NOTE: every signal written here gets a value on every path, so no latches are inferred.
    always_comb begin
        xfer         = mod_valid && mod_ready;
        // The buffer stays closed through the frame_done cycle of its own frame; don't regrant it.
        host_pending = buf_closed && !(frame_done && !active_src);
        grant        = ((state == ST_IDLE) || (state == ST_SLEEP)) && (beacon_pending || host_pending);
        last_payload = (byte_cnt == frame_len - 8'd1);
        rd_next      = xfer && !active_src &&
                       ((state == ST_LEN) || ((state == ST_PAYLOAD) && !last_payload));
        release_buf  = frame_done && !active_src;
        next_idx     = (state == ST_LEN) ? 8'd0 : byte_cnt + 8'd1;
        payload_next = active_src ? beacon_byte(next_idx, seq) : buf_rd_data;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            beacon_timer   <= '0;
            beacon_pending <= 1'b0;
        end else if (!beacon_en) begin
            beacon_timer   <= '0;
            beacon_pending <= 1'b0;
        end else begin
            if (grant && beacon_pending) beacon_pending <= 1'b0;
            if (beacon_timer == BCN_W'(BEACON_PERIOD - 1)) begin
                beacon_timer   <= '0;
                beacon_pending <= 1'b1;
            end else begin
                beacon_timer <= beacon_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SLEEP;
            mod_sleep  <= 1'b1;
            mod_valid  <= 1'b0;
            mod_data   <= '0;
            frame_done <= 1'b0;
            active_src <= 1'b0;
            byte_cnt   <= '0;
            wait_cnt   <= '0;
            frame_len  <= '0;
            csum       <= '0;
            seq        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (frame_done && active_src) seq <= seq + 8'd1;
            if (grant) begin
                active_src <= beacon_pending;
                frame_len  <= beacon_pending ? BEACON_LEN : buf_count;
            end

            case (state)
                ST_SLEEP: begin
                    if (grant) begin
                        state     <= ST_WAKE;
                        mod_sleep <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                ST_WAKE: begin
                    if (wait_cnt == WAIT_W'(WAKE_CYCLES - 1)) begin
                        state     <= ST_PREAMBLE;
                        mod_valid <= 1'b1;
                        mod_data  <= PREAMBLE_BYTE;
                        byte_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (grant) begin
                        state     <= ST_PREAMBLE;
                        mod_valid <= 1'b1;
                        mod_data  <= PREAMBLE_BYTE;
                        byte_cnt  <= '0;
                    end else if (wait_cnt == WAIT_W'(IDLE_CYCLES - 1)) begin
                        state     <= ST_SLEEP;
                        mod_sleep <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (xfer) begin
                        if (byte_cnt == 8'(PREAMBLE_BYTES - 1)) begin
                            state    <= ST_SYNC;
                            mod_data <= SYNC_WORD;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        state    <= ST_LEN;
                        mod_data <= frame_len;
                        csum     <= frame_len;
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        state    <= ST_PAYLOAD;
                        mod_data <= payload_next;
                        byte_cnt <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        csum <= csum + mod_data;
                        if (last_payload) begin
                            state    <= ST_CSUM;
                            mod_data <= csum + mod_data;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                            mod_data <= payload_next;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        state      <= ST_IDLE;
                        mod_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        wait_cnt   <= '0;
                    end
                end
                default: state <= ST_SLEEP;
            endcase
        end
    end

endmodule
